// File: rtl/maple_bus_xfer_sched.sv
// rtl/maple_bus_xfer_sched.sv - Maple bus half-duplex transaction sequencer (TX, turnaround, RX wait, gap).
// Optional timeout retry is enabled by defining MAPLE_SCHED_RETRY_EN.
module maple_bus_xfer_sched #(
  parameter int TO_W        = 24,
  parameter int TURN_CYCLES = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [TO_W-1:0] timeout_cycles_i,
  output logic            tx_start_o,
  input  logic            tx_done_i,
  output logic            bus_oe_o,
  output logic            rx_arm_o,
  input  logic            rx_frame_done_i,
  input  logic            rx_error_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [1:0]      status_o,
  output logic [1:0]      retries_o
);

  localparam int PH_MAX = (TURN_CYCLES > GAP_CYCLES) ? TURN_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_RX_ERR  = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

  if (TURN_CYCLES < 1 || GAP_CYCLES < 1 || MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_param
    $error("maple_bus_xfer_sched: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_TURN, S_RX_WAIT, S_DONE, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_lat_q, to_lat_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [1:0]        status_q, status_d;
  logic              tx_start_q, tx_start_d;
  logic              bus_oe_q, bus_oe_d;
  logic              rx_arm_q, rx_arm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              active;
  logic              expired;
`ifdef MAPLE_SCHED_RETRY_EN
  logic [1:0]        retries_q, retries_d;
  logic              retry_pend_q, retry_pend_d;
`endif

  always_comb begin
    state_d    = state_q;
    to_lat_d   = to_lat_q;
    to_cnt_d   = to_cnt_q;
    ph_d       = ph_q;
    status_d   = status_q;
    tx_start_d = 1'b0;
`ifdef MAPLE_SCHED_RETRY_EN
    retries_d    = retries_q;
    retry_pend_d = retry_pend_q;
`endif
    active  = (state_q == S_TX) || (state_q == S_TURN) || (state_q == S_RX_WAIT);
    // A latched timeout of zero disables expiry entirely.
    expired = (to_lat_q != '0) && (to_cnt_q == TO_W'(1));

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_TX;
          tx_start_d = 1'b1;
          to_lat_d   = timeout_cycles_i;
`ifdef MAPLE_SCHED_RETRY_EN
          retries_d    = 2'd0;
          retry_pend_d = 1'b0;
`endif
        end
      end
      S_TX: begin
        if (tx_done_i) begin
          state_d = S_TURN;
          ph_d    = PH_W'(TURN_CYCLES - 1);
        end
      end
      S_TURN: begin
        to_cnt_d = to_lat_q;
        if (ph_q == '0) state_d = S_RX_WAIT;
        else            ph_d    = ph_q - 1'b1;
      end
      S_RX_WAIT: begin
        if (to_lat_q != '0) to_cnt_d = to_cnt_q - 1'b1;
        // Error outranks a frame in the same cycle; a frame outranks expiry.
        if (rx_error_i) begin
          state_d  = S_DONE;
          status_d = ST_RX_ERR;
        end else if (rx_frame_done_i) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (expired) begin
`ifdef MAPLE_SCHED_RETRY_EN
          if (retries_q < 2'(MAX_RETRY)) begin
            state_d      = S_GAP;
            ph_d         = PH_W'(GAP_CYCLES - 1);
            retry_pend_d = 1'b1;
          end else begin
            state_d  = S_DONE;
            status_d = ST_TIMEOUT;
          end
`else
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
`endif
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        ph_d    = PH_W'(GAP_CYCLES - 1);
      end
      S_GAP: begin
        if (ph_q == '0) begin
`ifdef MAPLE_SCHED_RETRY_EN
          if (retry_pend_q) begin
            state_d      = S_TX;
            tx_start_d   = 1'b1;
            retries_d    = retries_q + 1'b1;
            retry_pend_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && active) begin
      state_d    = S_DONE;
      status_d   = ST_ABORT;
      tx_start_d = 1'b0;
    end

    // Outputs are decoded from the next state so they are registered yet state-aligned.
    bus_oe_d = (state_d == S_TX);
    rx_arm_d = (state_d == S_RX_WAIT);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      to_lat_q   <= '0;
      to_cnt_q   <= '0;
      ph_q       <= '0;
      status_q   <= ST_OK;
      tx_start_q <= 1'b0;
      bus_oe_q   <= 1'b0;
      rx_arm_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MAPLE_SCHED_RETRY_EN
      retries_q    <= 2'd0;
      retry_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      to_lat_q   <= to_lat_d;
      to_cnt_q   <= to_cnt_d;
      ph_q       <= ph_d;
      status_q   <= status_d;
      tx_start_q <= tx_start_d;
      bus_oe_q   <= bus_oe_d;
      rx_arm_q   <= rx_arm_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MAPLE_SCHED_RETRY_EN
      retries_q    <= retries_d;
      retry_pend_q <= retry_pend_d;
`endif
    end
  end

  assign tx_start_o = tx_start_q;
  assign bus_oe_o   = bus_oe_q;
  assign rx_arm_o   = rx_arm_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign status_o   = status_q;
`ifdef MAPLE_SCHED_RETRY_EN
  assign retries_o  = retries_q;
`else
  assign retries_o  = 2'd0;
`endif

endmodule
